// File: rtl/bram_stream_pkg.sv
// rtl/bram_stream_pkg.sv - shared types and sizing helpers for the BRAM stream reader
package bram_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int MAX_RD_LATENCY = 4;

  // Room for every read that can be in flight plus the registered output stage.
  function automatic int fifo_depth(input int rd_latency);
    return rd_latency + 2;
  endfunction

endpackage

// File: rtl/bram_stream_fifo.sv
// rtl/bram_stream_fifo.sv - first-word-fall-through FIFO with a registered output stage
module bram_stream_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk_in1,
  input  logic             aresetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             load_out;
  logic             from_mem;
  logic             bypass;
  logic             mem_push;

  // The output register may be refilled when it is empty or being consumed.
  assign load_out = !rd_valid || rd_ready;
  assign from_mem = load_out && (count != '0);
  assign bypass   = load_out && (count == '0) && wr_en;
  assign mem_push = wr_en && !bypass;

  always_ff @(posedge clk_in1 or negedge aresetn) begin
    if (!aresetn) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (from_mem) begin
        rd_valid <= 1'b1;
        rd_data  <= mem[rd_ptr];
        rd_ptr   <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end else if (bypass) begin
        rd_valid <= 1'b1;
        rd_data  <= wr_data;
      end else if (load_out) begin
        rd_valid <= 1'b0;
      end
      if (mem_push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      count <= count + CW'(mem_push) - CW'(from_mem);
    end
  end

  always_ff @(posedge clk_in1) begin
    if (mem_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - reads a BRAM region and emits it as AXI-Stream packets, optionally looping
module bram_stream_reader
  import bram_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk_in1,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_loop,
  input  logic                  stop,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int LAT = (RD_LATENCY < 1) ? 1 :
                       (RD_LATENCY > MAX_RD_LATENCY) ? MAX_RD_LATENCY : RD_LATENCY;
  localparam int FIFO_DEPTH = fifo_depth(LAT);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  rem;
  logic                  loop_q;
  logic [CW-1:0]         credit;
  logic [LAT-1:0]        sr_vld;
  logic [LAT-1:0]        sr_last;
  logic                  accept;
  logic                  final_read;
  logic                  beat_hs;
  logic                  fifo_wr;
  logic [DATA_WIDTH:0]   fifo_wdata;
  logic [DATA_WIDTH:0]   fifo_rdata;

  assign accept     = cmd_valid && cmd_ready;
  assign bram_en    = (state == ST_RUN) && (credit < CW'(FIFO_DEPTH));
  assign final_read = bram_en && (rem == LEN_WIDTH'(1));
  assign beat_hs    = m_axis_tvalid && m_axis_tready;
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk_in1 or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b0;
      bram_addr <= '0;
      base_addr <= '0;
      len_q     <= '0;
      rem       <= '0;
      loop_q    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            base_addr <= cmd_addr;
            bram_addr <= cmd_addr;
            len_q     <= cmd_len;
            rem       <= cmd_len;
            loop_q    <= cmd_loop;
            if (cmd_len == '0) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else begin
              state     <= ST_RUN;
              cmd_ready <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (bram_en) begin
            if (rem == LEN_WIDTH'(1)) begin
              // Region boundary: restart without a gap unless looping has been stopped.
              if (loop_q && !stop) begin
                rem       <= len_q;
                bram_addr <= base_addr;
              end else begin
                state <= ST_DRAIN;
              end
            end else begin
              rem       <= rem - 1'b1;
              bram_addr <= bram_addr + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (beat_hs && (credit == CW'(1))) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            done      <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  // Credits cover reads in flight and words buffered, so the FIFO can never overflow.
  always_ff @(posedge clk_in1 or negedge aresetn) begin
    if (!aresetn) begin
      credit  <= '0;
      sr_vld  <= '0;
      sr_last <= '0;
    end else begin
      credit     <= credit + CW'(bram_en) - CW'(beat_hs);
      sr_vld[0]  <= bram_en;
      sr_last[0] <= final_read;
      for (int i = 1; i < LAT; i++) begin
        sr_vld[i]  <= sr_vld[i-1];
        sr_last[i] <= sr_last[i-1];
      end
    end
  end

  assign fifo_wr    = sr_vld[LAT-1];
  assign fifo_wdata = {sr_last[LAT-1], bram_dout};

  bram_stream_fifo #(
    .WIDTH(DATA_WIDTH + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_in1 (clk_in1),
    .aresetn (aresetn),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .rd_valid(m_axis_tvalid),
    .rd_data (fifo_rdata),
    .rd_ready(m_axis_tready)
  );

  assign m_axis_tlast = fifo_rdata[DATA_WIDTH];
  assign m_axis_tdata = fifo_rdata[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb/tb_bram_stream_reader.sv - directed vector bench for bram_stream_reader
module tb_bram_stream_reader;

  localparam int DW = 64;
  localparam int AW = 12;
  localparam int LW = 16;
  localparam int RL = 2;

  logic          clk_in1 = 1'b0;
  logic          aresetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          cmd_loop = 1'b0;
  logic          stop = 1'b0;
  logic          bram_en;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_dout;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic          busy;
  logic          done;
  logic          err;

  bram_stream_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .RD_LATENCY(RL)
  ) dut (
    .clk_in1(clk_in1), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_loop(cmd_loop), .stop(stop),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .busy(busy), .done(done), .err(err)
  );

  initial forever #5 clk_in1 = ~clk_in1;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return {32'hDA7A5EED, 20'h0, a};
  endfunction

  // Two-stage read pipeline modelling a BRAM with RD_LATENCY = 2.
  logic [DW-1:0] bram_s1, bram_s2;
  always @(posedge clk_in1) begin
    if (bram_en) bram_s1 <= word_of(bram_addr);
    bram_s2 <= bram_s1;
  end
  assign bram_dout = bram_s2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc, first_valid_cyc, done_cyc, err_cyc, done_cnt, err_cnt;
  int en_count, hs_total, max_out, stall_viol;
  logic [DW:0] beats[$];
  int          beat_cyc[$];
  int          en_cyc[$];
  logic          prev_valid, prev_ready, prev_last;
  logic [DW-1:0] prev_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    beats.delete(); beat_cyc.delete(); en_cyc.delete();
    acc_cyc = -1; first_valid_cyc = -1; done_cyc = -1; err_cyc = -1;
    done_cnt = 0; err_cnt = 0; en_count = 0; hs_total = 0; max_out = 0; stall_viol = 0;
  endtask

  initial forever begin
    @(posedge clk_in1);
    cyc++;
  end

  initial begin
    prev_valid = 1'b0; prev_ready = 1'b0; prev_last = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk_in1);
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (bram_en) begin en_count++; en_cyc.push_back(cyc); end
      if (m_axis_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_axis_tvalid && m_axis_tready) begin
        beats.push_back({m_axis_tlast, m_axis_tdata});
        beat_cyc.push_back(cyc);
        hs_total++;
      end
      if (en_count - hs_total > max_out) max_out = en_count - hs_total;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err) begin err_cnt++; err_cyc = cyc; end
      if (aresetn && prev_valid && !prev_ready &&
          (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last))
        stall_viol++;
      prev_valid = aresetn && m_axis_tvalid;
      prev_ready = m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  task automatic tick();
    @(posedge clk_in1);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic lp);
    int n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    if (!cmd_ready) check("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_loop = lp;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin tick(); n++; end
    if (done_cnt == 0) check("done_timeout", 64'(done_cnt), 64'd1);
    tick(); tick();
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [AW-1:0] last_addr;
    int            done_lat;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{addr: 12'h010, len: 16'd8, last_addr: 12'h017, done_lat: 12};
    vecs[1] = '{addr: 12'hFFE, len: 16'd4, last_addr: 12'h001, done_lat: 8};
    vecs[2] = '{addr: 12'h000, len: 16'd1, last_addr: 12'h000, done_lat: 5};
    vecs[3] = '{addr: 12'h7FE, len: 16'd3, last_addr: 12'h800, done_lat: 7};
    clear_mon();

    // Reset state
    repeat (3) @(posedge clk_in1);
    #1;
    check("rst_ctrl", 64'({cmd_ready, m_axis_tvalid, m_axis_tlast, bram_en, busy, done, err, bram_addr}), 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    aresetn = 1'b1;
    tick();
    check("ready_after_rst", 64'(cmd_ready), 64'd1);

    // Single-pass vectors with tready held high
    m_axis_tready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      clear_mon();
      issue(vecs[v].addr, vecs[v].len, 1'b0);
      check($sformatf("v%0d_busy", v), 64'(busy), 64'd1);
      wait_done(100);
      check($sformatf("v%0d_first_lat", v), 64'(first_valid_cyc - acc_cyc), 64'd4);
      check($sformatf("v%0d_nbeats", v), 64'(beats.size()), 64'(vecs[v].len));
      for (int i = 0; i < beats.size(); i++) begin
        logic [AW-1:0] a;
        a = vecs[v].addr + AW'(i);
        check($sformatf("v%0d_beat%0d", v, i), 64'(beats[i][DW-1:0]), word_of(a));
        check($sformatf("v%0d_last%0d", v, i), 64'(beats[i][DW]), 64'(i == int'(vecs[v].len) - 1));
      end
      if (beats.size() > 0)
        check($sformatf("v%0d_final_word", v), beats[beats.size()-1][DW-1:0], word_of(vecs[v].last_addr));
      check($sformatf("v%0d_done_lat", v), 64'(done_cyc - acc_cyc), 64'(vecs[v].done_lat));
      check($sformatf("v%0d_done_once", v), 64'(done_cnt), 64'd1);
      check($sformatf("v%0d_no_err", v), 64'(err_cnt), 64'd0);
      check($sformatf("v%0d_reads", v), 64'(en_count), 64'(vecs[v].len));
      check($sformatf("v%0d_idle", v), 64'({busy, cmd_ready}), 64'b01);
    end

    // Zero length
    clear_mon();
    issue(12'h123, 16'd0, 1'b0);
    tick(); tick();
    check("zero_done_lat", 64'(done_cyc - acc_cyc), 64'd1);
    check("zero_err_lat", 64'(err_cyc - acc_cyc), 64'd1);
    check("zero_reads", 64'(en_count), 64'd0);
    check("zero_beats", 64'(beats.size()), 64'd0);
    check("zero_ready", 64'({busy, cmd_ready}), 64'b01);

    // Full stall: only FIFO_DEPTH reads issue, then one-cycle resume after first handshake
    clear_mon();
    m_axis_tready = 1'b0;
    issue(12'h500, 16'd10, 1'b0);
    repeat (20) tick();
    check("stall_reads", 64'(en_count), 64'd4);
    check("stall_beats", 64'(beats.size()), 64'd0);
    check("stall_head", {63'd0, m_axis_tvalid}, 64'd1);
    check("stall_head_data", m_axis_tdata, word_of(12'h500));
    m_axis_tready = 1'b1;
    wait_done(100);
    if (en_cyc.size() > 4 && beat_cyc.size() > 0)
      check("stall_resume", 64'(en_cyc[4] - beat_cyc[0]), 64'd1);
    else
      check("stall_resume_missing", 64'(en_cyc.size()), 64'd5);
    check("stall_nbeats", 64'(beats.size()), 64'd10);
    for (int i = 0; i < beats.size(); i++)
      check($sformatf("stall_beat%0d", i), beats[i][DW-1:0], word_of(12'h500 + AW'(i)));

    // Random backpressure, 100 words
    clear_mon();
    issue(12'hF80, 16'd100, 1'b0);
    for (int n = 0; n < 2000 && done_cnt == 0; n++) begin
      m_axis_tready = 1'($urandom_range(0, 1));
      tick();
    end
    m_axis_tready = 1'b1;
    wait_done(50);
    check("bp_nbeats", 64'(beats.size()), 64'd100);
    begin
      int bad = 0;
      for (int i = 0; i < beats.size(); i++)
        if (beats[i] !== {i == 99, word_of(12'hF80 + AW'(i))}) bad++;
      check("bp_data_order", 64'(bad), 64'd0);
    end
    check("bp_stall_stable", 64'(stall_viol), 64'd0);
    check("bp_credit_max", 64'(max_out > 4), 64'd0);

    // Loop with stop raised during pass 3
    clear_mon();
    issue(12'h040, 16'd3, 1'b1);
    repeat (7) tick();
    stop = 1'b1;
    wait_done(100);
    stop = 1'b0;
    check("loop_nbeats", 64'(beats.size()), 64'd9);
    begin
      int gaps = 0, lasts = 0;
      for (int i = 0; i < beats.size(); i++) begin
        check($sformatf("loop_beat%0d", i), beats[i][DW-1:0], word_of(12'h040 + AW'(i % 3)));
        if (beats[i][DW]) lasts++;
        if (beats[i][DW] !== (i % 3 == 2)) gaps++;
        if (i > 0 && beat_cyc[i] != beat_cyc[i-1] + 1) gaps++;
      end
      check("loop_packets", 64'(lasts), 64'd3);
      check("loop_no_gaps", 64'(gaps), 64'd0);
    end
    if (beat_cyc.size() > 0)
      check("loop_done_lat", 64'(done_cyc - beat_cyc[beat_cyc.size()-1]), 64'd1);
    check("loop_reads", 64'(en_count), 64'd9);

    // Reset mid-transfer
    clear_mon();
    issue(12'h200, 16'd20, 1'b0);
    for (int n = 0; n < 100 && beats.size() < 5; n++) tick();
    check("mid_beats_before_rst", 64'(beats.size()), 64'd5);
    aresetn = 1'b0;
    #1;
    check("mid_rst_ctrl", 64'({cmd_ready, m_axis_tvalid, m_axis_tlast, bram_en, busy, done, err, bram_addr}), 64'd0);
    check("mid_rst_tdata", m_axis_tdata, 64'd0);
    clear_mon();
    repeat (4) tick();
    check("mid_rst_quiet", 64'(beats.size() + done_cnt + en_count), 64'd0);
    aresetn = 1'b1;
    tick();
    issue(12'h300, 16'd4, 1'b0);
    wait_done(100);
    check("post_rst_nbeats", 64'(beats.size()), 64'd4);
    for (int i = 0; i < beats.size(); i++)
      check($sformatf("post_rst_beat%0d", i), 64'(beats[i][DW-1:0]), word_of(12'h300 + AW'(i)));
    check("post_rst_done", 64'(done_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
